// File: rtl/echo_indication_output.sv
// Echo indication transmit path: heard(meth, v) calls are queued in a small
// FIFO and emitted as tagged pipe messages {v, meth, tag} over an ENA/RDY pipe.
module echo_indication_output #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] TAG_HEARD = 32'd1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             indication_heard__ENA,
    input  logic [31:0]      indication_heard_meth,
    input  logic [31:0]      indication_heard_v,
    output logic             indication_heard__RDY,
    output logic             pipe_enq__ENA,
    output logic [95:0]      pipe_enq_v,
    input  logic             pipe_enq__RDY,
    output logic [CNT_W-1:0] sent_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]       PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       wr_ptr_d;
    logic [AW:0]       rd_ptr_q;
    logic [AW:0]       rd_ptr_d;
    logic [CNT_W-1:0]  sent_count_q;
    logic [CNT_W-1:0]  sent_count_d;
    logic [31:0]       meth_mem_q [DEPTH];
    logic [31:0]       v_mem_q    [DEPTH];

    logic              empty_s;
    logic              full_s;
    logic              enq_accept_s;
    logic              deq_s;
    logic [AW-1:0]     wr_idx_s;
    logic [AW-1:0]     rd_idx_s;

    // Occupancy flags derived purely from registered pointers.
    always_comb begin
        wr_idx_s = wr_ptr_q[AW-1:0];
        rd_idx_s = rd_ptr_q[AW-1:0];
        empty_s  = (wr_ptr_q == rd_ptr_q);
        full_s   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    end

    // Handshakes and next-state for pointers and the delivery counter.
    // heard__RDY comes from registered full, so a same-cycle dequeue does not
    // open the input until the following cycle.
    always_comb begin
        enq_accept_s = 1'b0;
        deq_s        = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        sent_count_d = sent_count_q;

        enq_accept_s = indication_heard__ENA && !full_s;
        deq_s        = !empty_s && pipe_enq__RDY;

        if (enq_accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (deq_s) begin
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
            sent_count_d = sent_count_q + CNT_ONE;
        end else begin
            rd_ptr_d     = rd_ptr_q;
            sent_count_d = sent_count_q;
        end
    end

    // Output message is built from the head entry; the tag is inserted here
    // rather than stored, and the bus reads zero whenever the FIFO is empty.
    always_comb begin
        indication_heard__RDY = !full_s;
        pipe_enq__ENA         = deq_s;
        sent_count            = sent_count_q;
        if (empty_s) begin
            pipe_enq_v = 96'd0;
        end else begin
            pipe_enq_v = {v_mem_q[rd_idx_s], meth_mem_q[rd_idx_s], TAG_HEARD};
        end
    end

    // Pointer and counter registers; reset discards any queued entries.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q     <= {(AW+1){1'b0}};
            rd_ptr_q     <= {(AW+1){1'b0}};
            sent_count_q <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            sent_count_q <= sent_count_d;
        end
    end

    // FIFO storage: written at the write pointer on every accepted call.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                meth_mem_q[i] <= 32'd0;
                v_mem_q[i]    <= 32'd0;
            end
        end else if (enq_accept_s) begin
            meth_mem_q[wr_idx_s] <= indication_heard_meth;
            v_mem_q[wr_idx_s]    <= indication_heard_v;
        end
    end

endmodule
